window_gen: RTL and testbench

- Upstream neighbour of the 3x3 convolution stage.
- Accepts a raster-order 8-bit pixel stream, one pixel per accepting cycle.
- Keeps the two previous image rows in on-chip line memories.
- Emits a packed 72-bit 3x3 neighbourhood with a valid strobe, wired directly to the convolution stage's window input. That stage has no backpressure, so neither does this block.

---
 rtl/img_pkg.sv | 16 +
 rtl/window_gen_if.sv | 33 +++
 rtl/window_gen_line_mem.sv | 25 ++
 rtl/window_gen.sv | 113 +++++++++++
 tb/tb_window_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: pixel width, default frame size and the
// 3x3 window packing order used by window_gen and the convolution stage.
package img_pkg;

  localparam int PIX_W          = 8;
  localparam int DEF_IMG_WIDTH  = 8;
  localparam int DEF_IMG_HEIGHT = 8;
  localparam int WIN_W          = 9 * PIX_W;

  // Bit offset of kernel tap (row, col); row 0 / col 0 is the top-left tap,
  // so the top-left lands in the MSBs and the current pixel in the LSBs.
  function automatic int win_idx(input int row, input int col);
    return (8 - row * 3 - col) * PIX_W;
  endfunction

endpackage

// File: rtl/window_gen_if.sv
// Pixel stream in, 3x3 neighbourhood out, for window_gen.
interface window_gen_if #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int PIX_W      = 8
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  // Valid-only streaming on both sides, no ready: a pixel (with its sof flag)
  // is taken on every clock where pix_valid=1, and a window is offered for
  // exactly the one cycle where window_valid=1; the consumer must take it.
  logic [PIX_W-1:0]   pix_in;
  logic               pix_valid;
  logic               sof;
  logic [9*PIX_W-1:0] window;
  logic               window_valid;
  logic [RW-1:0]      out_row;
  logic [CW-1:0]      out_col;
  logic               frame_done;

  modport master (
    output pix_in, pix_valid, sof,
    input  window, window_valid, out_row, out_col, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output window, window_valid, out_row, out_col, frame_done
  );

endinterface

// File: rtl/window_gen_line_mem.sv
// One image row of pixel storage: synchronous write, combinational read at
// the same column index.
module line_mem #(
  parameter int DEPTH = 8,
  parameter int PIX_W = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen.sv
// Raster pixel stream to 3x3 neighbourhood generator feeding the convolution
// stage; two line memories hold the previous two rows.
module window_gen #(
  parameter int IMG_WIDTH  = img_pkg::DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = img_pkg::DEF_IMG_HEIGHT,
  parameter int PIX_W      = img_pkg::PIX_W
) (
  input  logic        clk,
  input  logic        reset,
  window_gen_if.slave bus
);

  import img_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cur_c;
  logic [RW-1:0] cur_r;
  logic          accept;
  logic          last_col;
  logic          last_row;

  logic [PIX_W-1:0] l1_rd;
  logic [PIX_W-1:0] l2_rd;

  logic [2:0][2:0][PIX_W-1:0] win;
  logic [9*PIX_W-1:0]         win_flat;
  logic                       valid_q;
  logic                       done_q;
  logic [RW-1:0]              orow_q;
  logic [CW-1:0]              ocol_q;

  assign accept = bus.pix_valid;

  // sof overrides the counters so a new frame always starts at (0,0).
  assign cur_c    = bus.sof ? '0 : col;
  assign cur_r    = bus.sof ? '0 : row;
  assign last_col = (cur_c == CW'(IMG_WIDTH - 1));
  assign last_row = (cur_r == RW'(IMG_HEIGHT - 1));

  line_mem #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_l1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_c),
    .wdata (bus.pix_in),
    .rdata (l1_rd)
  );

  line_mem #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_l2 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_c),
    .wdata (l1_rd),
    .rdata (l2_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      row     <= '0;
      col     <= '0;
      win     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (accept) begin
        if (!last_col) begin
          col <= cur_c + CW'(1);
          row <= cur_r;
        end else begin
          col <= '0;
          row <= last_row ? '0 : cur_r + RW'(1);
        end
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= l2_rd;
        win[1][2] <= l1_rd;
        win[2][2] <= bus.pix_in;
        // Columns 0 and 1 still hold the tail of the previous row.
        if (cur_r >= RW'(2) && cur_c >= CW'(2)) begin
          valid_q <= 1'b1;
          orow_q  <= cur_r - RW'(1);
          ocol_q  <= cur_c - CW'(1);
        end
        done_q <= last_row && last_col;
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_flat[win_idx(i, j) / img_pkg::PIX_W * PIX_W +: PIX_W] = win[i][j];
      end
    end
  end

  assign bus.window       = win_flat;
  assign bus.window_valid = valid_q;
  assign bus.out_row      = orow_q;
  assign bus.out_col      = ocol_q;
  assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen: a 4x4 instance for the directed
// scenarios and an 8x8 instance for a random frame, against a frame-array model.
module tb_window_gen;
  import img_pkg::*;

  logic clk = 1'b0;
  logic reset;

  window_gen_if #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) bus4 ();
  window_gen_if #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .PIX_W(8)) bus8 ();

  window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .PIX_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and reference model state
  int          n_checks = 0;
  int          n_pass   = 0;
  int          sel      = 0;
  int          img_w    = 4;
  int          img_h    = 4;
  int          mr, mc;
  logic [7:0]  img [8][8];
  logic [71:0] exp_q [$];
  bit          exp_valid, exp_fd, exp_win_zero;
  int          exp_orow, exp_ocol;

  int          n_valid, n_fd;
  bit          have_first;
  logic [71:0] first_win, last_win;
  int          first_orow, first_ocol;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expectation for the cycle after this input, from frame position rules.
  task automatic model(input bit rst, input bit v, input bit s, input logic [7:0] p);
    int r, c;
    logic [71:0] w;
    exp_win_zero = 1'b0;
    exp_valid    = 1'b0;
    exp_fd       = 1'b0;
    if (rst) begin
      mr = 0;
      mc = 0;
      exp_orow     = 0;
      exp_ocol     = 0;
      exp_win_zero = 1'b1;
      exp_q.delete();
    end else if (v) begin
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        w = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w = {w[63:0], img[r-2+i][c-2+j]};
        exp_q.push_back(w);
        exp_valid = 1'b1;
        exp_orow  = r - 1;
        exp_ocol  = c - 1;
      end
      exp_fd = (r == img_h - 1) && (c == img_w - 1);
      if (c < img_w - 1) begin
        mc = c + 1;
        mr = r;
      end else begin
        mc = 0;
        mr = (r == img_h - 1) ? 0 : r + 1;
      end
    end
  endtask

  // driver: one clock of stimulus, then compare every output of the selected DUT
  task automatic step(input bit rst, input bit v, input bit s, input logic [7:0] p);
    logic [71:0] d_win;
    bit          d_valid, d_fd;
    int          d_orow, d_ocol;
    reset = rst;
    if (sel == 0) begin
      bus4.pix_valid = v; bus4.sof = s; bus4.pix_in = p;
    end else begin
      bus8.pix_valid = v; bus8.sof = s; bus8.pix_in = p;
    end
    model(rst, v, s, p);
    @(posedge clk);
    #1;
    if (sel == 0) begin
      d_win = bus4.window; d_valid = bus4.window_valid; d_fd = bus4.frame_done;
      d_orow = int'(bus4.out_row); d_ocol = int'(bus4.out_col);
    end else begin
      d_win = bus8.window; d_valid = bus8.window_valid; d_fd = bus8.frame_done;
      d_orow = int'(bus8.out_row); d_ocol = int'(bus8.out_col);
    end
    check("window_valid", 72'(d_valid), 72'(exp_valid));
    check("frame_done", 72'(d_fd), 72'(exp_fd));
    check("out_row", 72'(d_orow), 72'(exp_orow));
    check("out_col", 72'(d_ocol), 72'(exp_ocol));
    if (exp_win_zero) check("window_after_reset", d_win, 72'h0);
    if (d_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_window", d_win, 72'hx);
      end else begin
        check("window", d_win, exp_q.pop_front());
      end
      if (!have_first) begin
        have_first = 1'b1;
        first_win  = d_win;
        first_orow = d_orow;
        first_ocol = d_ocol;
      end
      last_win = d_win;
    end
    if (d_fd) n_fd++;
  endtask

  task automatic clear_stats();
    n_valid    = 0;
    n_fd       = 0;
    have_first = 1'b0;
    first_win  = '0;
    last_win   = '0;
  endtask

  // Streams the first n pixels of a frame; pixel value base+16*r+c or random.
  task automatic send_frame(input int base, input bit use_sof, input bit gaps,
                            input bit rnd, input int n);
    int r, c;
    logic [7:0] pix;
    for (int k = 0; k < n; k++) begin
      r = k / img_w;
      c = k % img_w;
      if (gaps) begin
        repeat ($urandom_range(0, 3)) step(0, 0, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      pix = rnd ? 8'($urandom) : 8'(base + 16 * r + c);
      step(0, 1, use_sof && (k == 0), pix);
    end
  endtask

  task automatic end_checks(input string tag, input int want_valid, input int want_fd);
    check({tag, "_n_valid"}, 72'(n_valid), 72'(want_valid));
    check({tag, "_n_frame_done"}, 72'(n_fd), 72'(want_fd));
    check({tag, "_leftover"}, 72'(exp_q.size()), 72'(0));
  endtask

  initial begin
    reset = 1'b1;
    bus4.pix_valid = 1'b0; bus4.sof = 1'b0; bus4.pix_in = '0;
    bus8.pix_valid = 1'b0; bus8.sof = 1'b0; bus8.pix_in = '0;

    // reset state of the 4x4 instance
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // basic frame
    clear_stats();
    send_frame(0, 1, 0, 0, 16);
    step(0, 0, 0, 0);
    end_checks("basic", 4, 1);
    check("basic_first_window", first_win, 72'h000102101112202122);
    check("basic_first_out_row", 72'(first_orow), 72'(1));
    check("basic_first_out_col", 72'(first_ocol), 72'(1));
    check("basic_last_window", last_win, 72'h111213212223313233);

    // same frame with idle bubbles
    clear_stats();
    send_frame(0, 1, 1, 0, 16);
    step(0, 0, 0, 0);
    end_checks("gaps", 4, 1);
    check("gaps_first_window", first_win, 72'h000102101112202122);
    check("gaps_last_window", last_win, 72'h111213212223313233);

    // back-to-back frames
    clear_stats();
    send_frame(8'h00, 1, 0, 0, 16);
    send_frame(8'h40, 1, 0, 0, 16);
    step(0, 0, 0, 0);
    end_checks("b2b", 8, 2);
    check("b2b_last_window", last_win, 72'h515253616263717273);

    // frame abandoned by sof at (2,1), then a full frame
    clear_stats();
    send_frame(8'h80, 1, 0, 0, 9);
    send_frame(8'h00, 1, 1, 0, 16);
    step(0, 0, 0, 0);
    end_checks("midsof", 4, 1);
    check("midsof_last_window", last_win, 72'h111213212223313233);

    // reset arriving with pixel (2,3), then a frame without sof
    clear_stats();
    send_frame(8'h00, 1, 0, 0, 11);
    step(1, 1, 0, 8'h23);
    send_frame(8'h20, 0, 0, 0, 16);
    step(0, 0, 0, 0);
    end_checks("rstmid", 5, 1);
    check("rstmid_last_window", last_win, 72'h313233414243515253);

    // default-size random frame with bubbles
    sel = 1;
    img_w = 8;
    img_h = 8;
    step(1, 0, 0, 0);
    clear_stats();
    send_frame(0, 1, 1, 1, 64);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    end_checks("rand8", 36, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
